// File: rtl/gradgen_pkg.sv
// Shared types and constants for the gradient sequencer.
// The optional SAMPLE acknowledge timeout is controlled by GRADGEN_ACK_TIMEOUT_EN.
package gradgen_pkg;

    localparam int CNT_W       = 16;
    localparam int ACK_TIMEOUT = 1024;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PRIME  = 3'd1,
        SETTLE = 3'd2,
        SAMPLE = 3'd3,
        FLUSH  = 3'd4
    } state_t;

    // The timer counts down to zero, so a state lasting N clocks loads N-1.
    function automatic logic [CNT_W-1:0] cnt_load(input int unsigned cycles);
        if (cycles == 32'd0) begin
            return {CNT_W{1'b0}};
        end else begin
            return CNT_W'(cycles - 32'd1);
        end
    endfunction

endpackage

// File: rtl/gradgen_timer.sv
// Loadable 16-bit down-counter shared by every timed state of the sequencer.
// Holds at zero once expired; a load always wins over counting.
module gradgen_timer
    import gradgen_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_r;

    // Count register: reload on state entry, otherwise decrement until zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (load) begin
            cnt_r <= load_val;
        end else if (cnt_r != {CNT_W{1'b0}}) begin
            cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign zero = (cnt_r == {CNT_W{1'b0}});

endmodule

// File: rtl/gradient_sequencer.sv
// Gradient sequencer: primes the inlet pumps, settles and samples each outlet, then flushes.
// Define GRADGEN_ACK_TIMEOUT_EN to add the SAMPLE acknowledge timeout and the sticky ack_err output.
module gradient_sequencer
    import gradgen_pkg::*;
#(
    parameter int N_OUT        = 6,
    parameter int PRIME_CYCLES = 64,
    parameter int FLUSH_CYCLES = 32,
    localparam int IDX_W       = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [15:0]      dwell_cycles,
    output logic             pump_a_en,
    output logic             pump_b_en,
    output logic [N_OUT-1:0] outlet_valve,
    output logic [IDX_W-1:0] outlet_idx,
    output logic             sample_req,
    input  logic             sample_ack,
    output logic             busy,
    output logic             done
`ifdef GRADGEN_ACK_TIMEOUT_EN
    ,output logic            ack_err
`endif
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_OUT - 1);
    localparam logic [CNT_W-1:0] ONE_CNT  = {{(CNT_W-1){1'b0}}, 1'b1};

`ifdef GRADGEN_ACK_TIMEOUT_EN
    localparam logic [CNT_W-1:0] SAMPLE_LOAD = cnt_load(ACK_TIMEOUT);
`else
    localparam logic [CNT_W-1:0] SAMPLE_LOAD = {CNT_W{1'b0}};
`endif

    state_t           state_r;
    state_t           next_state_s;
    logic [CNT_W-1:0] dwell_r;
    logic [IDX_W-1:0] idx_next_s;
    logic             tmr_load_s;
    logic [CNT_W-1:0] tmr_val_s;
    logic             tmr_zero_s;
    logic             timeout_s;

    gradgen_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load_s),
        .load_val (tmr_val_s),
        .zero     (tmr_zero_s)
    );

    // Next-state, timer reload and outlet index decisions.
    always_comb begin
        next_state_s = state_r;
        idx_next_s   = outlet_idx;
        tmr_load_s   = 1'b0;
        tmr_val_s    = {CNT_W{1'b0}};
        timeout_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    next_state_s = PRIME;
                    idx_next_s   = {IDX_W{1'b0}};
                    tmr_load_s   = 1'b1;
                    tmr_val_s    = cnt_load(PRIME_CYCLES);
                end else begin
                    next_state_s = IDLE;
                end
            end
            PRIME: begin
                if (abort) begin
                    next_state_s = FLUSH;
                    tmr_load_s   = 1'b1;
                    tmr_val_s    = cnt_load(FLUSH_CYCLES);
                end else if (tmr_zero_s) begin
                    next_state_s = SETTLE;
                    tmr_load_s   = 1'b1;
                    tmr_val_s    = dwell_r - ONE_CNT;
                end else begin
                    next_state_s = PRIME;
                end
            end
            SETTLE: begin
                if (abort) begin
                    next_state_s = FLUSH;
                    tmr_load_s   = 1'b1;
                    tmr_val_s    = cnt_load(FLUSH_CYCLES);
                end else if (tmr_zero_s) begin
                    next_state_s = SAMPLE;
                    tmr_load_s   = 1'b1;
                    tmr_val_s    = SAMPLE_LOAD;
                end else begin
                    next_state_s = SETTLE;
                end
            end
            SAMPLE: begin
`ifdef GRADGEN_ACK_TIMEOUT_EN
                timeout_s = tmr_zero_s & ~sample_ack & ~abort;
`else
                timeout_s = 1'b0;
`endif
                // Abort outranks an acknowledge arriving in the same cycle.
                if (abort) begin
                    next_state_s = FLUSH;
                    tmr_load_s   = 1'b1;
                    tmr_val_s    = cnt_load(FLUSH_CYCLES);
                end else if (sample_ack || timeout_s) begin
                    if (outlet_idx == LAST_IDX) begin
                        next_state_s = FLUSH;
                        tmr_load_s   = 1'b1;
                        tmr_val_s    = cnt_load(FLUSH_CYCLES);
                    end else begin
                        next_state_s = SETTLE;
                        idx_next_s   = outlet_idx + {{(IDX_W-1){1'b0}}, 1'b1};
                        tmr_load_s   = 1'b1;
                        tmr_val_s    = dwell_r - ONE_CNT;
                    end
                end else begin
                    next_state_s = SAMPLE;
                end
            end
            FLUSH: begin
                if (tmr_zero_s) begin
                    next_state_s = IDLE;
                    tmr_load_s   = 1'b1;
                    tmr_val_s    = {CNT_W{1'b0}};
                end else begin
                    next_state_s = FLUSH;
                end
            end
            default: begin
                next_state_s = IDLE;
                tmr_load_s   = 1'b1;
                tmr_val_s    = {CNT_W{1'b0}};
            end
        endcase
    end

    // State register and registered outputs, decoded from the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            dwell_r      <= ONE_CNT;
            outlet_idx   <= {IDX_W{1'b0}};
            pump_a_en    <= 1'b0;
            pump_b_en    <= 1'b0;
            outlet_valve <= {N_OUT{1'b0}};
            sample_req   <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
`ifdef GRADGEN_ACK_TIMEOUT_EN
            ack_err      <= 1'b0;
`endif
        end else begin
            state_r    <= next_state_s;
            outlet_idx <= idx_next_s;
            busy       <= (next_state_s != IDLE);
            done       <= (state_r == FLUSH) && (next_state_s == IDLE);
            if ((state_r == IDLE) && start) begin
                dwell_r <= (dwell_cycles == 16'd0) ? ONE_CNT : dwell_cycles;
            end else begin
                dwell_r <= dwell_r;
            end
`ifdef GRADGEN_ACK_TIMEOUT_EN
            if ((state_r == IDLE) && start) begin
                ack_err <= 1'b0;
            end else if (timeout_s) begin
                ack_err <= 1'b1;
            end else begin
                ack_err <= ack_err;
            end
`endif
            case (next_state_s)
                PRIME: begin
                    pump_a_en    <= 1'b1;
                    pump_b_en    <= 1'b1;
                    outlet_valve <= {N_OUT{1'b0}};
                    sample_req   <= 1'b0;
                end
                SETTLE: begin
                    pump_a_en    <= 1'b1;
                    pump_b_en    <= 1'b1;
                    outlet_valve <= {{(N_OUT-1){1'b0}}, 1'b1} << idx_next_s;
                    sample_req   <= 1'b0;
                end
                SAMPLE: begin
                    pump_a_en    <= 1'b1;
                    pump_b_en    <= 1'b1;
                    outlet_valve <= {{(N_OUT-1){1'b0}}, 1'b1} << idx_next_s;
                    sample_req   <= 1'b1;
                end
                FLUSH: begin
                    pump_a_en    <= 1'b0;
                    pump_b_en    <= 1'b0;
                    outlet_valve <= {N_OUT{1'b1}};
                    sample_req   <= 1'b0;
                end
                default: begin
                    pump_a_en    <= 1'b0;
                    pump_b_en    <= 1'b0;
                    outlet_valve <= {N_OUT{1'b0}};
                    sample_req   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gradient_sequencer.sv
// Scoreboard bench for gradient_sequencer: runs push expected sample requests and done pulses,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_gradient_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [15:0] dwell_cycles;
    logic        pump_a_en, pump_b_en;
    logic [5:0]  outlet_valve;
    logic [2:0]  outlet_idx;
    logic        sample_req;
    logic        sample_ack;
    logic        busy;
    logic        done;
`ifdef GRADGEN_ACK_TIMEOUT_EN
    logic        ack_err;
`endif

    gradient_sequencer #(.N_OUT(6), .PRIME_CYCLES(64), .FLUSH_CYCLES(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .dwell_cycles (dwell_cycles),
        .pump_a_en    (pump_a_en),
        .pump_b_en    (pump_b_en),
        .outlet_valve (outlet_valve),
        .outlet_idx   (outlet_idx),
        .sample_req   (sample_req),
        .sample_ack   (sample_ack),
        .busy         (busy),
        .done         (done)
`ifdef GRADGEN_ACK_TIMEOUT_EN
        ,.ack_err     (ack_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit is_done;
        int idx;
        int t;
        bit err;
    } ev_t;

    ev_t exp_q[$];
    int  total = 0;
    int  bad   = 0;
    int  cyc   = 0;
    int  ack_mode  = 0;   // 0 normal, 1 normal plus stray ack in SETTLE, 2 never ack, 3 abort with ack
    int  abort_idx = 7;
    logic req_d = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic score(input bit is_done);
        ev_t e;
        logic [5:0] v;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_event actual=%s at cycle %0d required=none", is_done ? "done" : "req", cyc);
            return;
        end
        e = exp_q.pop_front();
        v = e.is_done ? 6'd0 : (6'd1 << e.idx);
        check("event_kind", is_done, e.is_done);
        check("event_cycle", cyc, e.t);
        check("outlet_idx", outlet_idx, e.idx);
        check("outlet_valve", outlet_valve, v);
        check("pumps", {pump_a_en, pump_b_en}, e.is_done ? 2'b00 : 2'b11);
        check("busy", busy, !e.is_done);
`ifdef GRADGEN_ACK_TIMEOUT_EN
        check("ack_err", ack_err, e.err);
`endif
    endtask

    // Monitor: a rising sample_req or any done cycle is one DUT event.
    always @(negedge clk) begin
        if (rst) begin
            req_d <= 1'b0;
        end else begin
            if (sample_req && !req_d) score(1'b0);
            if (done) score(1'b1);
            req_d <= sample_req;
        end
    end

    // Sensor model: acknowledge two cycles after each request appears.
    initial begin
        sample_ack = 1'b0;
        abort      = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && sample_req && ack_mode != 2) begin
                @(negedge clk);
                sample_ack = 1'b1;
                if (ack_mode == 3 && outlet_idx == abort_idx[2:0]) abort = 1'b1;
                @(negedge clk);
                sample_ack = 1'b0;
                abort      = 1'b0;
                if (ack_mode == 1) begin
                    repeat (3) @(negedge clk);
                    sample_ack = 1'b1;
                    @(negedge clk);
                    sample_ack = 1'b0;
                end
            end
        end
    end

    task automatic do_start(input logic [15:0] dw, output int s);
        @(negedge clk);
        start        = 1'b1;
        dwell_cycles = dw;
        @(negedge clk);
        start = 1'b0;
        s     = cyc;
    endtask

    task automatic push_run(input int s, input int first, input int period, input int last,
                            input int done_t, input bit tmode);
        for (int i = 0; i <= last; i++) begin
            exp_q.push_back('{is_done: 1'b0, idx: i, t: s + first + i * period, err: tmode && (i > 0)});
        end
        exp_q.push_back('{is_done: 1'b1, idx: last, t: s + done_t, err: tmode});
    endtask

    task automatic drain(input int limit);
        int n = 0;
        while (exp_q.size() > 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout actual=%0d pending required=0 pending", exp_q.size());
            exp_q.delete();
        end
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int s;
        rst          = 1'b1;
        start        = 1'b0;
        dwell_cycles = 16'd0;

        @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_req", sample_req, 1'b0);
        check("rst_valve", outlet_valve, 6'd0);
        check("rst_idx", outlet_idx, 3'd0);
        check("rst_pumps", {pump_a_en, pump_b_en}, 2'b00);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Nominal: 64 prime + 6*(10 settle + 2 ack) + 32 flush.
        ack_mode = 0;
        do_start(16'd10, s);
        push_run(s, 74, 12, 5, 168, 1'b0);
        drain(400);

        // Dwell zero behaves as dwell one.
        do_start(16'd0, s);
        push_run(s, 65, 3, 5, 114, 1'b0);
        drain(400);

        // Abort together with ack at outlet 3.
        ack_mode  = 3;
        abort_idx = 3;
        do_start(16'd10, s);
        push_run(s, 74, 12, 3, 144, 1'b0);
        repeat (112) @(negedge clk);
        check("abort_valve", outlet_valve, 6'h3f);
        check("abort_pumps", {pump_a_en, pump_b_en}, 2'b00);
        check("abort_req", sample_req, 1'b0);
        check("abort_idx", outlet_idx, 3'd3);
        check("abort_busy", busy, 1'b1);
        drain(400);
        ack_mode  = 0;
        abort_idx = 7;

        // Start while busy and stray acks in SETTLE change nothing.
        ack_mode = 1;
        do_start(16'd10, s);
        push_run(s, 74, 12, 5, 168, 1'b0);
        repeat (80) @(negedge clk);
        start        = 1'b1;
        dwell_cycles = 16'd3;
        @(negedge clk);
        start = 1'b0;
        drain(400);
        ack_mode = 0;

        // Reset in SETTLE of outlet 1, then restart from outlet 0.
        do_start(16'd10, s);
        push_run(s, 74, 12, 5, 168, 1'b0);
        repeat (80) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_pumps", {pump_a_en, pump_b_en}, 2'b00);
        check("midrst_valve", outlet_valve, 6'd0);
        check("midrst_idx", outlet_idx, 3'd0);
        check("midrst_req", sample_req, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        do_start(16'd10, s);
        push_run(s, 74, 12, 5, 168, 1'b0);
        drain(400);

`ifdef GRADGEN_ACK_TIMEOUT_EN
        // Never acknowledge: each SAMPLE times out after 1024 clocks.
        ack_mode = 2;
        do_start(16'd10, s);
        push_run(s, 74, 1034, 5, 6300, 1'b1);
        drain(7000);
        ack_mode = 0;
        do_start(16'd0, s);
        push_run(s, 65, 3, 5, 114, 1'b0);
        drain(400);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
